// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: key whitening, then 10 or 14 issues of one
// shared round datapath, with round-key indexing and last-round flagging.
module aes_round_sequencer #(
    parameter int DATA_WIDTH = 128,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_state,
    input  logic                  key_len,
    output logic [IDX_WIDTH-1:0]  rk_idx,
    input  logic [DATA_WIDTH-1:0] rk_data,
    output logic                  rnd_valid,
    output logic [DATA_WIDTH-1:0] rnd_state,
    output logic                  rnd_last,
    input  logic                  rnd_valid_in,
    input  logic [DATA_WIDTH-1:0] rnd_state_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_state,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    state_e                fsm_q, fsm_d;
    logic [IDX_WIDTH-1:0]  round_q, round_d;
    logic [DATA_WIDTH-1:0] state_q, state_d;
    logic                  nr_q, nr_d;

    logic [IDX_WIDTH-1:0]  nr_rounds;
    logic                  is_last;

    assign nr_rounds = nr_q ? IDX_WIDTH'(14) : IDX_WIDTH'(10);
    assign is_last   = (round_q == nr_rounds);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            nr_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            nr_q    <= nr_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        round_d   = round_q;
        state_d   = state_q;
        nr_d      = nr_q;
        in_ready  = 1'b0;
        rk_idx    = '0;
        rnd_valid = 1'b0;
        rnd_state = '0;
        rnd_last  = 1'b0;
        out_valid = 1'b0;
        out_state = '0;
        busy      = 1'b1;

        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = in_state ^ rk_data;
                    nr_d    = key_len;
                    round_d = IDX_WIDTH'(1);
                    fsm_d   = ISSUE;
                end
            end
            ISSUE: begin
                rnd_valid = 1'b1;
                rnd_state = state_q;
                rk_idx    = round_q;
                rnd_last  = is_last;
                fsm_d     = WAIT;
            end
            WAIT: begin
                // Key must stay put: the datapath reads it combinationally.
                rk_idx = round_q;
                if (rnd_valid_in) begin
                    state_d = rnd_state_in;
                    if (is_last) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q + IDX_WIDTH'(1);
                        fsm_d   = ISSUE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_state = state_q;
                if (out_ready) begin
                    round_d = '0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative controller that runs one shared AES round datapath repeatedly to encrypt a 128-bit block. It accepts a plaintext block, applies initial key whitening, and issues 10 (AES-128) or 14 (AES-256) round operations. It drives round-key indices to the key store and flags the final round so the datapath selects its last-round path (no MixColumns). The sequencer sits between the block-level valid/ready interface and the round/lastRound datapath plus the round-key memory.

## Interface
- DATA_WIDTH, 128: block width; fixed at 128.
- IDX_WIDTH, 4: round-key index width; covers indices 0..14.

- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  sequencer can accept a block.
- in_state  in  DATA_WIDTH  plaintext.
- key_len  in  1  sampled on accept: 0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14).
- rk_idx  out  IDX_WIDTH  round-key index to the key store.
- rk_data  in  DATA_WIDTH  round key for rk_idx, combinational, same cycle.
- rnd_valid  out  1  one-cycle strobe issuing a round.
- rnd_state  out  DATA_WIDTH  state to datapath; valid while rnd_valid=1.
- rnd_last  out  1  current issue is the final round.
- rnd_valid_in  in  1  datapath result valid.
- rnd_state_in  in  DATA_WIDTH  datapath result.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes ciphertext.
- out_state  out  DATA_WIDTH  ciphertext.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1 and rk_idx=0.
  - On in_valid=1: state_reg <= in_state ^ rk_data, nr_reg <= key_len, round <= 1, go to ISSUE.
- ISSUE:
  - rnd_valid=1, rnd_state=state_reg, rk_idx=round.
  - rnd_last=1 iff round == Nr (10 or 14).
  - Go to WAIT next cycle unconditionally.
- WAIT:
  - rk_idx holds at round, because the datapath samples the key combinationally.
  - On rnd_valid_in=1: state_reg <= rnd_state_in.
  - If round == Nr, go to DONE; otherwise round <= round+1 and go to ISSUE.
  - rnd_valid_in=0: remain in WAIT indefinitely; there is no timeout.
- DONE:
  - out_valid=1, out_state=state_reg.
  - On out_ready=1, go to IDLE; the next block is accepted one cycle later, with no same-cycle turnaround.
- rnd_valid_in asserted outside WAIT is ignored and does not alter state_reg.
- key_len and in_state are sampled only at acceptance. Changes during the operation have no effect.
- round is a 4-bit counter that never exceeds Nr, so no wrap-around occurs.
- rk_idx is 0 in IDLE and DONE.

## Timing
- Reset values:
  - FSM=IDLE, round=0, state_reg=0, nr_reg=0.
  - in_ready=1, rnd_valid=0, rnd_last=0, rk_idx=0.
  - out_valid=0, out_state=0, busy=0.
- rst during any state returns to IDLE on the next edge. An in-flight block is discarded, and late rnd_valid_in pulses are ignored.
- Per round: 1 issue cycle plus the datapath latency L (registered SubBytes gives L=1). Each round therefore takes 2 cycles at L=1.
- Latency from the accept edge (cycle 0) to out_valid:
  - AES-128: 1 + 10·(1+L) cycles, which is 21 at L=1.
  - AES-256: 1 + 14·(1+L) cycles, which is 29 at L=1.
- At most one round is in flight in the datapath at any time. rnd_valid is never asserted twice without an intervening rnd_valid_in.
- out_valid, once set, stays high with out_state stable until out_ready is sampled high.

## Test plan
- AES-128: accept in_state=00112233445566778899aabbccddeeff with key schedule from key 000102…0f and key_len=0. Required: out_state=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid rising exactly 21 cycles after accept; rnd_last high only on the 10th issue; rk_idx sequence 0,1..10.
- AES-256: same plaintext, key 000102…1f, key_len=1. Required: out_state=8ea2b7ca516745bfeafc49904b496089 at cycle 29; rnd_last only on the 14th issue.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Required: out_valid and out_state stable, in_ready=0, and a new in_valid is not accepted. Release out_ready, then check IDLE/in_ready=1 on the next cycle.
- Stretched datapath: model L=3, plus a spurious rnd_valid_in pulse during ISSUE and during IDLE. Required: the correct AES-128 result at cycle 1+10·4=41, unaffected by the spurious pulses.
- Reset mid-operation: assert rst for 1 cycle in WAIT of round 5. Required: all outputs at reset values the next cycle. A following block encrypts correctly with the nominal latency.
- key_len toggled mid-block: key_len=0 at accept, then 1 during rounds. Required: exactly 10 rounds are issued.
